// File: rtl/jtframe_sdram_arb.sv
// rtl/jtframe_sdram_arb.sv - Round-robin SDRAM command arbiter with download port and refresh scheduling
module jtframe_sdram_arb #(
    parameter int         BANKS       = 4,
    parameter int         SDRAMW      = 23,
    parameter logic [3:0] WRMASK      = 4'b0001,
    parameter int         RFSH_PERIOD = 390,
    parameter int         RFSH_MAX    = 8
) (
    input  logic                      clk_rom,
    input  logic                      rst_n,
    input  logic                      downloading,
    input  logic [SDRAMW-1:0]         prog_addr,
    input  logic [1:0]                prog_ba,
    input  logic [15:0]               prog_data,
    input  logic [1:0]                prog_mask,
    input  logic                      prog_we,
    input  logic                      prog_rd,
    output logic                      prog_ack,
    output logic                      prog_rdy,
    input  logic [BANKS*SDRAMW-1:0]   ba_addr,
    input  logic [BANKS-1:0]          ba_rd,
    input  logic [BANKS-1:0]          ba_wr,
    input  logic [BANKS*16-1:0]       ba_din,
    input  logic [BANKS*2-1:0]        ba_din_m,
    output logic [BANKS-1:0]          ba_ack,
    output logic [BANKS-1:0]          ba_rdy,
    output logic [15:0]               dout,
    input  logic                      rfsh_en,
    output logic [SDRAMW-1:0]         ctl_addr,
    output logic [1:0]                ctl_ba,
    output logic                      ctl_rd,
    output logic                      ctl_wr,
    output logic                      ctl_rfsh,
    output logic [15:0]               ctl_din,
    output logic [1:0]                ctl_dm,
    input  logic                      ctl_ack,
    input  logic                      ctl_rdy,
    input  logic [15:0]               ctl_dout
);

    localparam int             RCW       = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
    localparam logic [RCW-1:0] RLAST     = RCW'(RFSH_PERIOD - 1);
    localparam logic [3:0]     PMAX      = 4'(RFSH_MAX);
    localparam logic [1:0]     LAST_BANK = 2'(BANKS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY, WAIT_RACK} state_t;

    state_t             state;
    logic [1:0]         rr;
    logic [1:0]         own_bank;
    logic               own_prog;
    logic [RCW-1:0]     rcnt;
    logic [3:0]         pend;

    logic [BANKS-1:0]   req;
    logic [BANKS-1:0]   own_hot;
    logic               gnt_found;
    logic [1:0]         gnt_idx;
    logic [1:0]         rr_next;
    logic [SDRAMW-1:0]  sel_addr;
    logic [15:0]        sel_din;
    logic [1:0]         sel_dm;
    logic               sel_wr;
    logic               rcnt_wrap;
    logic               rfsh_done;

    // A bank whose WRMASK bit is clear can only request through ba_rd.
    always_comb begin
        req     = '0;
        own_hot = '0;
        for (int i = 0; i < BANKS; i++) begin
            req[i]     = ba_rd[i] | (ba_wr[i] & WRMASK[i]);
            own_hot[i] = (own_bank == 2'(i));
        end
    end

    // Lowest requester at or after rr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = 2'(i);
            end
        end
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (req[i] && (2'(i) >= rr)) begin
                gnt_idx = 2'(i);
            end
        end
        rr_next = (gnt_idx == LAST_BANK) ? 2'd0 : gnt_idx + 2'd1;
    end

    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_dm   = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < BANKS; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel_addr = ba_addr[i*SDRAMW +: SDRAMW];
                sel_din  = ba_din[i*16 +: 16];
                sel_dm   = ba_din_m[i*2 +: 2];
                sel_wr   = ba_wr[i] & WRMASK[i];
            end
        end
    end

    assign rcnt_wrap = (rcnt == RLAST);
    assign rfsh_done = (state == WAIT_RACK) && ctl_ack;

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= 2'd0;
            own_bank <= 2'd0;
            own_prog <= 1'b0;
            rcnt     <= '0;
            pend     <= 4'd0;
            prog_ack <= 1'b0;
            prog_rdy <= 1'b0;
            ba_ack   <= '0;
            ba_rdy   <= '0;
            dout     <= 16'd0;
            ctl_addr <= '0;
            ctl_ba   <= 2'd0;
            ctl_rd   <= 1'b0;
            ctl_wr   <= 1'b0;
            ctl_rfsh <= 1'b0;
            ctl_din  <= 16'd0;
            ctl_dm   <= 2'd0;
        end else begin
            rcnt <= rcnt_wrap ? '0 : rcnt + RCW'(1);
            // A credit arriving together with a completed refresh cancels out.
            if (rcnt_wrap && !rfsh_done && (pend != PMAX)) begin
                pend <= pend + 4'd1;
            end else if (rfsh_done && !rcnt_wrap) begin
                pend <= pend - 4'd1;
            end

            prog_ack <= 1'b0;
            prog_rdy <= 1'b0;
            ba_ack   <= '0;
            ba_rdy   <= '0;

            case (state)
                IDLE: begin
                    if (pend == PMAX) begin
                        ctl_rfsh <= 1'b1;
                        state    <= WAIT_RACK;
                    end else if (downloading && (prog_we || prog_rd)) begin
                        ctl_addr <= prog_addr;
                        ctl_ba   <= prog_ba;
                        ctl_din  <= prog_data;
                        ctl_dm   <= prog_mask;
                        ctl_wr   <= prog_we;
                        ctl_rd   <= !prog_we;
                        own_prog <= 1'b1;
                        state    <= WAIT_ACK;
                    end else if (rfsh_en && (pend != 4'd0)) begin
                        ctl_rfsh <= 1'b1;
                        state    <= WAIT_RACK;
                    end else if (!downloading && gnt_found) begin
                        ctl_addr <= sel_addr;
                        ctl_ba   <= gnt_idx;
                        ctl_din  <= sel_din;
                        ctl_dm   <= sel_dm;
                        ctl_wr   <= sel_wr;
                        ctl_rd   <= !sel_wr;
                        own_prog <= 1'b0;
                        own_bank <= gnt_idx;
                        rr       <= rr_next;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ctl_ack) begin
                        ctl_rd <= 1'b0;
                        ctl_wr <= 1'b0;
                        if (own_prog) begin
                            prog_ack <= 1'b1;
                        end else begin
                            ba_ack <= own_hot;
                        end
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ctl_rdy) begin
                        dout <= ctl_dout;
                        if (own_prog) begin
                            prog_rdy <= 1'b1;
                        end else begin
                            ba_rdy <= own_hot;
                        end
                        state <= IDLE;
                    end
                end
                WAIT_RACK: begin
                    if (ctl_ack) begin
                        ctl_rfsh <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// tb/tb_jtframe_sdram_arb.sv - Randomized scoreboard bench for jtframe_sdram_arb
module tb_jtframe_sdram_arb;

    localparam int         B    = 4;
    localparam int         SW   = 23;
    localparam logic [3:0] WM   = 4'b0101;
    localparam int         RP   = 4;
    localparam int         RMAX = 2;

    localparam int K_NONE = 0, K_RFSH = 1, K_PROG = 2, K_BANK = 3;
    localparam int PH_IDLE = 0, PH_ACK = 1, PH_RDY = 2, PH_RACK = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              downloading;
    logic [SW-1:0]     prog_addr;
    logic [1:0]        prog_ba;
    logic [15:0]       prog_data;
    logic [1:0]        prog_mask;
    logic              prog_we, prog_rd;
    logic              prog_ack, prog_rdy;
    logic [B*SW-1:0]   ba_addr;
    logic [B-1:0]      ba_rd, ba_wr;
    logic [B*16-1:0]   ba_din;
    logic [B*2-1:0]    ba_din_m;
    logic [B-1:0]      ba_ack, ba_rdy;
    logic [15:0]       dout;
    logic              rfsh_en;
    logic [SW-1:0]     ctl_addr;
    logic [1:0]        ctl_ba;
    logic              ctl_rd, ctl_wr, ctl_rfsh;
    logic [15:0]       ctl_din;
    logic [1:0]        ctl_dm;
    logic              ctl_ack, ctl_rdy;
    logic [15:0]       ctl_dout;

    jtframe_sdram_arb #(
        .BANKS(B), .SDRAMW(SW), .WRMASK(WM), .RFSH_PERIOD(RP), .RFSH_MAX(RMAX)
    ) dut (
        .clk_rom(clk), .rst_n(rst_n), .downloading(downloading),
        .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_we(prog_we), .prog_rd(prog_rd),
        .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_din(ba_din),
        .ba_din_m(ba_din_m), .ba_ack(ba_ack), .ba_rdy(ba_rdy), .dout(dout),
        .rfsh_en(rfsh_en), .ctl_addr(ctl_addr), .ctl_ba(ctl_ba), .ctl_rd(ctl_rd),
        .ctl_wr(ctl_wr), .ctl_rfsh(ctl_rfsh), .ctl_din(ctl_din), .ctl_dm(ctl_dm),
        .ctl_ack(ctl_ack), .ctl_rdy(ctl_rdy), .ctl_dout(ctl_dout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ecount = 0;
    bit started = 0;
    bit quiet = 0;
    bit force_beef = 0;

    always @(posedge clk) ecount <= ecount + 1;

    // Requester-side state: 0 idle, 1 requesting, 2 granted and awaiting rdy.
    logic [SW-1:0] q_addr[B];
    logic          q_rd[B], q_wr[B];
    logic [15:0]   q_din[B];
    logic [1:0]    q_dm[B];
    int            r_st[B], r_tmr[B];
    bit            r_keep[B];
    int            p_st, p_tmr;
    bit            p_keep;

    // Reference model: arbiter phase, refresh credits, round-robin pointer.
    int            m_phase, m_pend, m_rr, e_cnt;
    logic [4:0]    m_owner;
    logic [15:0]   m_dout;

    logic [4:0]    ackq_own[$];
    int            ackq_edge[$];
    logic [4:0]    rdyq_own[$];
    logic [15:0]   rdyq_dat[$];
    int            rdyq_edge[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit bank_req(int i);
        return q_rd[i] | (q_wr[i] & WM[i]);
    endfunction

    task automatic pack();
        for (int i = 0; i < B; i++) begin
            ba_addr[i*SW +: SW]  = q_addr[i];
            ba_rd[i]             = q_rd[i];
            ba_wr[i]             = q_wr[i];
            ba_din[i*16 +: 16]   = q_din[i];
            ba_din_m[i*2 +: 2]   = q_dm[i];
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < B; i++) begin
            q_addr[i] = '0; q_rd[i] = 0; q_wr[i] = 0; q_din[i] = '0; q_dm[i] = '0;
            r_st[i] = 0; r_tmr[i] = 0; r_keep[i] = 0;
        end
        p_st = 0; p_tmr = 0; p_keep = 0;
        prog_addr = '0; prog_ba = '0; prog_data = '0; prog_mask = '0;
        prog_we = 0; prog_rd = 0; downloading = 0; rfsh_en = 0;
        ctl_ack = 0; ctl_rdy = 0; ctl_dout = '0;
        pack();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk("rst_handshake", 64'({prog_ack, prog_rdy, ba_ack, ba_rdy}), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_ctl_flags", 64'({ctl_rd, ctl_wr, ctl_rfsh, ctl_ba, ctl_dm}), 64'(0));
        chk("rst_ctl_addr", 64'(ctl_addr), 64'(0));
        chk("rst_ctl_din", 64'(ctl_din), 64'(0));
        m_phase = PH_IDLE; m_pend = 0; m_rr = 0; e_cnt = 0; m_owner = '0; m_dout = '0;
        ackq_own.delete(); ackq_edge.delete();
        rdyq_own.delete(); rdyq_dat.delete(); rdyq_edge.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic new_bank_req(int i);
        int t;
        t = $urandom_range(0, 3);
        q_rd[i]   = (t != 2);
        q_wr[i]   = (t >= 2);
        q_addr[i] = SW'($urandom);
        q_din[i]  = 16'($urandom);
        q_dm[i]   = 2'($urandom);
        r_keep[i] = ($urandom_range(0, 3) != 0);
        r_tmr[i]  = 30;
        r_st[i]   = 1;
    endtask

    task automatic set_bank2_read();
        q_rd[2] = 1; q_wr[2] = 0; q_addr[2] = 23'h1234; q_din[2] = 16'h0; q_dm[2] = 2'b00;
        r_keep[2] = 1; r_tmr[2] = 1000; r_st[2] = 1;
        pack();
    endtask

    // One clock of the closed loop: inputs currently on the wires are those the DUT just sampled.
    task automatic step();
        int         kind, gi, best, d, t;
        bit         w, dec;
        logic [15:0] dat;
        kind = K_NONE; gi = 0; dec = 0;
        if (m_pend == RMAX) kind = K_RFSH;
        else if (downloading && (prog_we || prog_rd)) kind = K_PROG;
        else if (rfsh_en && m_pend > 0) kind = K_RFSH;
        else if (!downloading) begin
            best = B;
            for (int i = 0; i < B; i++) begin
                d = (i - m_rr + B) % B;
                if (bank_req(i) && d < best) begin best = d; gi = i; end
            end
            if (best < B) kind = K_BANK;
        end

        case (m_phase)
            PH_IDLE: begin
                if (kind == K_NONE) begin
                    chk("idle_no_cmd", 64'({ctl_rd, ctl_wr, ctl_rfsh}), 64'(3'b000));
                end else if (kind == K_RFSH) begin
                    chk("rfsh_cmd", 64'({ctl_rd, ctl_wr, ctl_rfsh}), 64'(3'b001));
                    m_phase = PH_RACK;
                end else if (kind == K_PROG) begin
                    chk("prog_cmd", 64'({ctl_rd, ctl_wr, ctl_rfsh}), 64'({!prog_we, prog_we, 1'b0}));
                    chk("prog_fields", 64'({ctl_addr, ctl_ba, ctl_din, ctl_dm}),
                        64'({prog_addr, prog_ba, prog_data, prog_mask}));
                    m_owner = 5'b10000; m_phase = PH_ACK;
                    p_st = 2;
                    if (!p_keep) begin prog_we = 0; prog_rd = 0; end
                end else begin
                    w = q_wr[gi] & WM[gi];
                    chk("bank_cmd", 64'({ctl_rd, ctl_wr, ctl_rfsh}), 64'({!w, w, 1'b0}));
                    chk("bank_fields", 64'({ctl_addr, ctl_ba, ctl_din, ctl_dm}),
                        64'({q_addr[gi], 2'(gi), q_din[gi], q_dm[gi]}));
                    m_owner = 5'(1 << gi); m_rr = (gi + 1) % B; m_phase = PH_ACK;
                    r_st[gi] = 2;
                    if (!r_keep[gi]) begin q_rd[gi] = 0; q_wr[gi] = 0; end
                end
            end
            PH_ACK:  if (ctl_ack) m_phase = PH_RDY;
            PH_RDY:  if (ctl_rdy) m_phase = PH_IDLE;
            default: if (ctl_ack) begin m_phase = PH_IDLE; dec = 1; end
        endcase

        e_cnt++;
        m_pend = m_pend - int'(dec);
        if ((e_cnt % RP) == 0 && m_pend < RMAX) m_pend++;

        ctl_ack = 0; ctl_rdy = 0;
        ctl_dout = 16'($urandom);
        case (m_phase)
            PH_ACK, PH_RACK: begin
                if ($urandom_range(0, 1) == 1) begin
                    ctl_ack = 1;
                    if (m_phase == PH_ACK) begin
                        ackq_own.push_back(m_owner); ackq_edge.push_back(ecount + 1);
                    end
                end else if ($urandom_range(0, 7) == 0) ctl_rdy = 1;
            end
            PH_RDY: begin
                if ($urandom_range(0, 1) == 1) begin
                    dat = force_beef ? 16'hBEEF : 16'($urandom);
                    ctl_dout = dat; ctl_rdy = 1;
                    rdyq_own.push_back(m_owner); rdyq_dat.push_back(dat);
                    rdyq_edge.push_back(ecount + 1);
                end else if ($urandom_range(0, 7) == 0) ctl_ack = 1;
            end
            default: begin
                if ($urandom_range(0, 9) == 0) ctl_ack = 1;
                if ($urandom_range(0, 9) == 0) ctl_rdy = 1;
            end
        endcase

        for (int i = 0; i < B; i++) begin
            case (r_st[i])
                1: begin
                    r_tmr[i]--;
                    if (r_tmr[i] == 0) begin q_rd[i] = 0; q_wr[i] = 0; r_st[i] = 0; end
                end
                2: begin
                    if (ba_ack[i]) begin q_rd[i] = 0; q_wr[i] = 0; end
                    if (ba_rdy[i]) r_st[i] = 0;
                end
                default: if (!quiet && $urandom_range(0, 5) == 0) new_bank_req(i);
            endcase
        end
        pack();

        case (p_st)
            1: begin
                p_tmr--;
                if (p_tmr == 0) begin prog_we = 0; prog_rd = 0; p_st = 0; end
            end
            2: begin
                if (prog_ack) begin prog_we = 0; prog_rd = 0; end
                if (prog_rdy) p_st = 0;
            end
            default: if (!quiet && $urandom_range(0, 4) == 0) begin
                t = $urandom_range(0, 3);
                prog_rd = (t != 2); prog_we = (t >= 2);
                prog_addr = SW'($urandom); prog_ba = 2'($urandom);
                prog_data = 16'($urandom); prog_mask = 2'($urandom);
                p_keep = ($urandom_range(0, 3) != 0); p_tmr = 30; p_st = 1;
            end
        endcase

        if (!quiet && $urandom_range(0, 39) == 0) downloading = !downloading;
        rfsh_en = ($urandom_range(0, 9) < 3);
    endtask

    // Monitor: every ack/rdy pulse must match the oldest expected completion.
    initial begin
        logic [4:0]  o;
        logic [15:0] dv;
        int          ed;
        forever begin
            @(posedge clk); #1;
            if (rst_n && started) begin
                if (ba_ack != '0 || prog_ack) begin
                    if (ackq_own.size() == 0) begin
                        chk("ack_unexpected", 64'({prog_ack, ba_ack}), 64'(0));
                    end else begin
                        o = ackq_own.pop_front(); ed = ackq_edge.pop_front();
                        chk("ack_owner", 64'({prog_ack, ba_ack}), 64'(o));
                        chk("ack_latency", 64'(ecount), 64'(ed));
                    end
                end
                if (ba_rdy != '0 || prog_rdy) begin
                    if (rdyq_own.size() == 0) begin
                        chk("rdy_unexpected", 64'({prog_rdy, ba_rdy}), 64'(0));
                    end else begin
                        o = rdyq_own.pop_front(); dv = rdyq_dat.pop_front(); ed = rdyq_edge.pop_front();
                        chk("rdy_owner", 64'({prog_rdy, ba_rdy}), 64'(o));
                        chk("rdy_latency", 64'(ecount), 64'(ed));
                        chk("rdy_dout", 64'(dout), 64'(dv));
                        m_dout = dv;
                    end
                end else begin
                    chk("dout_hold", 64'(dout), 64'(m_dout));
                end
            end
        end
    end

    initial begin
        bit hit;
        clear_inputs();
        @(negedge clk);
        do_reset();
        started = 1;

        quiet = 0;
        repeat (3000) begin @(negedge clk); step(); end
        quiet = 1; downloading = 0;
        repeat (200) begin @(negedge clk); step(); end

        set_bank2_read();
        hit = 0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk); step();
            if (m_phase == PH_RDY && m_owner == 5'b00100) hit = 1;
        end
        chk("reset_setup_reached", 64'(hit), 64'(1));
        do_reset();

        force_beef = 1;
        @(negedge clk); step();
        set_bank2_read();
        hit = 0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk); step();
            if (r_st[2] == 0) hit = 1;
        end
        chk("post_reset_read_done", 64'(hit), 64'(1));
        chk("post_reset_read_dout", 64'(dout), 64'(16'hBEEF));
        force_beef = 0;

        quiet = 0;
        repeat (1500) begin @(negedge clk); step(); end
        quiet = 1; downloading = 0;
        repeat (200) begin @(negedge clk); step(); end

        chk("ack_queue_drained", 64'(ackq_own.size()), 64'(0));
        chk("rdy_queue_drained", 64'(rdyq_own.size()), 64'(0));
        for (int i = 0; i < B; i++) chk("bank_requester_idle", 64'(r_st[i]), 64'(0));
        chk("prog_requester_idle", 64'(p_st), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
